// File: rtl/dp_memory_if.sv
// Port bundle for dp_memory: two read/write ports, clear request and status flags.
// The master side drives requests; the slave side (the memory) returns read data and status.
interface dp_memory_if #(
  parameter int DATA_W = 10,
  parameter int ADDR_W = 5
);
  logic              we_A;
  logic              we_B;
  logic              re_A;
  logic              re_B;
  logic [ADDR_W-1:0] address_A;
  logic [ADDR_W-1:0] address_B;
  logic [DATA_W-1:0] data_in_A;
  logic [DATA_W-1:0] data_in_B;
  logic              clear;
  logic [DATA_W-1:0] data_out_A;
  logic [DATA_W-1:0] data_out_B;
  logic              valid_A;
  logic              valid_B;
  logic              busy;
  logic              collision;

  modport master (
    output we_A, we_B, re_A, re_B, address_A, address_B, data_in_A, data_in_B, clear,
    input  data_out_A, data_out_B, valid_A, valid_B, busy, collision
  );

  modport slave (
    input  we_A, we_B, re_A, re_B, address_A, address_B, data_in_A, data_in_B, clear,
    output data_out_A, data_out_B, valid_A, valid_B, busy, collision
  );
endinterface

// File: rtl/dp_memory.sv
// Dual-port register-file memory with port-B write priority and a one-entry-per-cycle clear sweep.
// Define DP_MEMORY_BYPASS_EN to return newly written data on a same-cycle read of that address.
module dp_memory #(
  parameter int DATA_W = 10,
  parameter int ADDR_W = 5
) (
  input logic          clk,
  input logic          reset,
  dp_memory_if.slave   bus
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] mem [DEPTH];

  logic accept;
  logic wr_a, wr_b, rd_a, rd_b;
  logic same_addr;
  logic [DATA_W-1:0] rd_data_a, rd_data_b;

  // Requests presented on the edge that accepts clear are dropped, as is everything during a sweep.
  assign accept    = (state_q == IDLE) && !bus.clear;
  assign wr_a      = accept && bus.we_A;
  assign wr_b      = accept && bus.we_B;
  assign rd_a      = accept && bus.re_A;
  assign rd_b      = accept && bus.re_B;
  assign same_addr = (bus.address_A == bus.address_B);
  assign bus.busy  = (state_q == CLEAR);

  // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    unique case (state_q)
      IDLE: begin
        if (bus.clear) state_d = CLEAR;
      end
      CLEAR: begin
        cnt_d = ADDR_W'(cnt_q + 1'b1);
        if (cnt_q == {ADDR_W{1'b1}}) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: the array is built from flops so it can be zeroed by the asynchronous reset; a RAM macro could not.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (state_q == CLEAR) begin
      mem[cnt_q] <= '0;
    end else begin
      if (wr_a && !(wr_b && same_addr)) mem[bus.address_A] <= bus.data_in_A;
      if (wr_b)                          mem[bus.address_B] <= bus.data_in_B;
    end
  end

  always_comb begin
    rd_data_a = mem[bus.address_A];
    rd_data_b = mem[bus.address_B];
`ifdef DP_MEMORY_BYPASS_EN
    if (wr_b && same_addr) rd_data_a = bus.data_in_B;
    else if (wr_a)         rd_data_a = bus.data_in_A;
    if (wr_b)                   rd_data_b = bus.data_in_B;
    else if (wr_a && same_addr) rd_data_b = bus.data_in_A;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.data_out_A <= '0;
      bus.data_out_B <= '0;
      bus.valid_A    <= 1'b0;
      bus.valid_B    <= 1'b0;
      bus.collision  <= 1'b0;
    end else begin
      bus.valid_A   <= rd_a;
      bus.valid_B   <= rd_b;
      bus.collision <= wr_a && wr_b && same_addr;
      if (rd_a) bus.data_out_A <= rd_data_a;
      if (rd_b) bus.data_out_B <= rd_data_b;
    end
  end
endmodule
